// File: rtl/fli_dff_pkg.sv
// Shared constants for the fli_dff storage primitive.
package fli_dff_pkg;

    // Default bank width: a single storage bit.
    localparam int unsigned FliDffDefaultWidth = 1;

endpackage

// File: rtl/fli_dff_bit.sv
// Single-bit D flip-flop cell with synchronous active-high reset and complementary output.
module fli_dff_bit #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic CK,
    input  logic RST,
    input  logic D,
    output logic Q,
    output logic QP
);

    logic q_q;

    // Storage: reset wins over D on a rising edge, otherwise load D.
    always_ff @(posedge CK) begin
        if (RST) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= D;
        end
    end

    // QP comes from the stored bit, so it never sees D directly.
    always_comb begin
        Q  = q_q;
        QP = ~q_q;
    end

endmodule

// File: rtl/fli_dff.sv
// Parameterized bank of independent D flip-flops sharing CK and RST.
module fli_dff
    import fli_dff_pkg::*;
#(
    parameter int unsigned             WIDTH       = FliDffDefaultWidth,
    parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QP
);

    // One cell per bit; each gets its own slice of the reset value.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fli_dff_bit #(
            .RESET_VALUE(RESET_VALUE[i])
        ) u_bit (
            .CK (CK),
            .RST(RST),
            .D  (D[i]),
            .Q  (Q[i]),
            .QP (QP[i])
        );
    end

endmodule

// File: tb/tb_fli_dff.sv
// Self-checking bench for fli_dff: table-driven vectors plus hold, reset-pulse and chain sequences.
module tb_fli_dff;

    logic       ck;
    logic       rst;
    logic [3:0] d;
    logic [3:0] q, qp, q_rv, qp_rv;

    logic       c_rst;
    logic       c_d0;
    logic [3:0] c_q, c_qp;

    int n_cmp = 0;
    int n_bad = 0;

    fli_dff #(.WIDTH(4)) u_dut (
        .CK(ck), .RST(rst), .D(d), .Q(q), .QP(qp)
    );

    fli_dff #(.WIDTH(4), .RESET_VALUE(4'b0110)) u_dut_rv (
        .CK(ck), .RST(rst), .D(d), .Q(q_rv), .QP(qp_rv)
    );

    fli_dff #(.WIDTH(1)) u_c0 (
        .CK(ck), .RST(c_rst), .D(c_d0), .Q(c_q[0]), .QP(c_qp[0])
    );
    fli_dff #(.WIDTH(1)) u_c1 (
        .CK(ck), .RST(c_rst), .D(c_q[0]), .Q(c_q[1]), .QP(c_qp[1])
    );
    fli_dff #(.WIDTH(1)) u_c2 (
        .CK(ck), .RST(c_rst), .D(c_q[1]), .Q(c_q[2]), .QP(c_qp[2])
    );
    fli_dff #(.WIDTH(1)) u_c3 (
        .CK(ck), .RST(c_rst), .D(c_q[2]), .Q(c_q[3]), .QP(c_qp[3])
    );

    // Period 20.
    initial begin
        ck = 1'b0;
        forever #10 ck = ~ck;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       rst;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic [3:0] exp_rv;
    } vec_t;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, need %b", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge ck);
        #1;
    endtask

    vec_t vecs[6];
    logic [3:0] exp_chain;

    initial begin
        rst   = 1'b1;
        d     = 4'b0000;
        c_rst = 1'b1;
        c_d0  = 1'b0;

        vecs[0] = '{rst: 1'b1, d: 4'b1001, exp_q: 4'b0000, exp_rv: 4'b0110};
        vecs[1] = '{rst: 1'b0, d: 4'b1010, exp_q: 4'b1010, exp_rv: 4'b1010};
        vecs[2] = '{rst: 1'b0, d: 4'b0101, exp_q: 4'b0101, exp_rv: 4'b0101};
        vecs[3] = '{rst: 1'b1, d: 4'b1111, exp_q: 4'b0000, exp_rv: 4'b0110};
        vecs[4] = '{rst: 1'b0, d: 4'b1111, exp_q: 4'b1111, exp_rv: 4'b1111};
        vecs[5] = '{rst: 1'b0, d: 4'b0011, exp_q: 4'b0011, exp_rv: 4'b0011};

        for (int i = 0; i < 6; i++) begin
            rst = vecs[i].rst;
            d   = vecs[i].d;
            step();
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_qp", i), qp, ~vecs[i].exp_q);
            check($sformatf("vec%0d_rv_q", i), q_rv, vecs[i].exp_rv);
            check($sformatf("vec%0d_rv_qp", i), qp_rv, ~vecs[i].exp_rv);
        end

        // Load and hold: D changes mid-cycle, Q waits for the next edge.
        rst = 1'b0;
        d   = 4'b0000;
        step();
        check("hold_q0", q, 4'b0000);
        #4;
        d = 4'b1111;
        #4;
        check("hold_mid_q", q, 4'b0000);
        check("hold_mid_qp", qp, 4'b1111);
        step();
        check("hold_load_q", q, 4'b1111);
        check("hold_load_qp", qp, 4'b0000);

        // RST pulse that does not cover a rising edge has no effect.
        d = 4'b0101;
        #4;
        rst = 1'b1;
        #4;
        rst = 1'b0;
        check("rst_glitch_q", q, 4'b1111);
        step();
        check("after_glitch_q", q, 4'b0101);

        // Four-stage chain: the 1 reaches stage k after k+1 edges.
        c_rst = 1'b1;
        step();
        check("chain_rst_q", c_q, 4'b0000);
        check("chain_rst_qp", c_qp, 4'b1111);
        c_rst = 1'b0;
        c_d0  = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            for (int k = 0; k < 4; k++) exp_chain[k] = (k + 1 <= n);
            check($sformatf("chain_e%0d_q", n), c_q, exp_chain);
            check($sformatf("chain_e%0d_qp", n), c_qp, ~exp_chain);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fli_dff.md
Name: fli_dff

Overview:
- Clocked D-type storage element with true (Q) and complementary (QP) outputs.
- Parameterized width: one instance can hold a single bit or a bank of independent bits sharing CK/RST.
- Leaf primitive for registers and shift chains; a chain is built by feeding one instance's Q into the next instance's D.

Parameters:
- WIDTH, 1, number of independent storage bits (must be >= 1).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q by reset.

Ports:
- CK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous reset, active-high, sampled on the rising edge of CK.
- D  input  WIDTH  data input, sampled on the rising edge of CK.
- Q  output  WIDTH  registered data output.
- QP  output  WIDTH  complement of Q (QP = ~Q, bitwise).

Behaviour:
- One clock (CK). Reset is synchronous and active-high.
- Rising edge of CK with RST=1: Q <= RESET_VALUE. D is ignored.
- Rising edge of CK with RST=0: Q <= D. All bits load in parallel.
- Latency: D is visible on Q one rising edge after it is sampled. There is no combinational path from D to Q or QP.
- QP is derived combinationally from the stored Q, never from D. QP == ~Q holds at all times, including the reset state.
  - With the default reset, Q = all zeros and QP = all ones.
- Between rising edges, Q and QP hold their value regardless of D or RST activity. Falling edges have no effect.
- Reset mid-operation: an RST pulse covering a rising edge overrides D on that edge only. Normal loading resumes on the first edge with RST=0.
- Power-up: before the first reset or first load edge, Q and QP are undefined (X in simulation). No initial value is guaranteed.
- Unknown D (X/Z) at a load edge propagates to Q, and its complement to QP. There is no masking.
- Bits are fully independent. There is no enable, no asynchronous set/clear and no internal bit-to-bit connection.
- Timing contract: D and RST must be stable around the rising edge of CK. Stimulus that changes D exactly on the edge is a bench race, not a design requirement.

Decomposition:
- No shared package required. WIDTH and RESET_VALUE are local parameters of this block.
- One natural sub-module: fli_dff_bit, a single-bit cell with CK, RST, D, Q, QP and a one-bit reset value.
  - fli_dff instantiates WIDTH copies in a generate loop.
  - Each copy receives the matching bit of RESET_VALUE.

Test Plan:
- Reset: WIDTH=4, CK period 20, RST=1 across the first rising edge -> Q=4'b0000, QP=4'b1111 after that edge.
- Load and hold: RST=0, D=4'b0000 until mid-cycle, then D=4'b1111 set 5 time units after an edge -> Q stays 0000 until the next rising edge, then Q=1111 and QP=0000.
- Per-bit independence: D=4'b1010 on one edge, then 4'b0101 on the next -> Q follows with one-edge latency; QP=~Q checked every cycle.
- Reset override: RST=1 while D=4'b1111 at an edge -> Q=0000. RST released -> next edge gives Q=1111.
- Non-default RESET_VALUE=4'b0110: reset edge -> Q=0110, QP=1001.
- Chain of four WIDTH=1 instances (Q of stage i drives D of stage i+1): reset, then stage-0 D=1 held -> the 1 reaches stage k after k+1 rising edges; all QP remain complements.
